// File: rtl/gcd_controller.sv
// -----------------------------------------------------------------------------
// gcd_controller
//   Control FSM for a subtract-and-compare GCD datapath. It loads operands A
//   and B through a valid/ready handshake. It then repeats COMPARE -> SUB_A /
//   SUB_B until the datapath reports A==B. The computation aborts through ERR
//   when the subtraction budget (MAX_ITER) runs out or the flags are
//   inconsistent.
//
// Parameters
//   MAX_ITER  maximum number of subtractions before an error abort
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   start     begin a computation (honoured only in IDLE)
//   in_valid  operand present on the datapath data_in bus
//   gt/lt/eq  datapath comparator status (A>B, A<B, A==B)
//   lda/ldb   load enables for datapath registers A and B
//   sel_1     subtractor minuend select   (1 = A, 0 = B)
//   sel_2     subtractor subtrahend select (1 = A, 0 = B)
//   sel_in    register input select (1 = subtractor, 0 = data_in)
//   in_ready  operand handshake ready
//   busy      high in every state except IDLE
//   done      one-cycle pulse at the end of every computation
//   err       one-cycle pulse with done when the computation aborts
//   iter_cnt  subtraction count, held after done until the next start
// -----------------------------------------------------------------------------
module gcd_controller #(
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic        gt,
  input  logic        lt,
  input  logic        eq,
  output logic        lda,
  output logic        ldb,
  output logic        sel_1,
  output logic        sel_2,
  output logic        sel_in,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] iter_cnt
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_ITER);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPARE,
    SUB_A,
    SUB_B,
    DONE,
    ERR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] iter_nxt;
  logic [2:0]  flags;
  logic        at_limit;

  // Flags packed as {gt, lt, eq}; a legal comparator drives exactly one.
  assign flags    = {gt, lt, eq};
  assign at_limit = (iter_cnt == MAX_CNT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of all others, independent of statement order.
  // Only the control state is reset here; the A/B data registers live in the
  // datapath and carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      iter_cnt <= '0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= iter_nxt;
    end
  end

  // NOTE: every output and next-state signal gets a default before the case
  // statement; a path that forgot one would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_cnt;
    lda       = 1'b0;
    ldb       = 1'b0;
    sel_1     = 1'b0;
    sel_2     = 1'b0;
    sel_in    = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;

    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          iter_nxt  = '0;
          state_nxt = LOAD_A;
        end
      end

      LOAD_A: begin
        in_ready = 1'b1;
        lda      = in_valid;
        if (in_valid) state_nxt = LOAD_B;
      end

      LOAD_B: begin
        in_ready = 1'b1;
        ldb      = in_valid;
        if (in_valid) state_nxt = COMPARE;
      end

      COMPARE: begin
        sel_in = 1'b1;
        // Equality wins even at the iteration limit; the budget check comes
        // before any further subtraction so iter_cnt stops at MAX_ITER.
        if (flags == 3'b001)      state_nxt = DONE;
        else if (at_limit)        state_nxt = ERR;
        else if (flags == 3'b100) state_nxt = SUB_A;
        else if (flags == 3'b010) state_nxt = SUB_B;
        else                      state_nxt = ERR;
      end

      SUB_A: begin
        sel_1     = 1'b1;
        sel_in    = 1'b1;
        lda       = 1'b1;
        iter_nxt  = at_limit ? iter_cnt : iter_cnt + 16'd1;
        state_nxt = COMPARE;
      end

      SUB_B: begin
        sel_2     = 1'b1;
        sel_in    = 1'b1;
        ldb       = 1'b1;
        iter_nxt  = at_limit ? iter_cnt : iter_cnt + 16'd1;
        state_nxt = COMPARE;
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// -----------------------------------------------------------------------------
// tb_gcd_controller
//   Self-checking bench for gcd_controller. A small behavioural datapath
//   (registers A/B, subtractor, comparator) sits around the controller. The
//   expected results come from a plain-arithmetic Euclid-by-subtraction model
//   with a subtraction budget. Directed scenarios run first, then randomized
//   operand pairs.
// -----------------------------------------------------------------------------
module tb_gcd_controller;

  localparam int unsigned MAX_ITER = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        gt, lt, eq;
  logic        lda, ldb, sel_1, sel_2, sel_in, in_ready, busy, done, err;
  logic [15:0] iter_cnt;

  // Behavioural datapath
  logic [15:0] data_in;
  logic [15:0] a_reg = '0;
  logic [15:0] b_reg = '0;
  logic [15:0] sub_res;
  logic        force_gt = 1'b0;
  logic        force_lt = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gcd_controller #(.MAX_ITER(MAX_ITER)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .gt       (gt),
    .lt       (lt),
    .eq       (eq),
    .lda      (lda),
    .ldb      (ldb),
    .sel_1    (sel_1),
    .sel_2    (sel_2),
    .sel_in   (sel_in),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .iter_cnt (iter_cnt)
  );

  assign sub_res = (sel_1 ? a_reg : b_reg) - (sel_2 ? a_reg : b_reg);
  assign gt      = (a_reg > b_reg) | force_gt;
  assign lt      = (a_reg < b_reg) | force_lt;
  assign eq      = (a_reg == b_reg);

  always @(posedge clk) begin
    if (lda) a_reg <= sel_in ? sub_res : data_in;
    if (ldb) b_reg <= sel_in ? sub_res : data_in;
  end

  // Reference: Euclid by subtraction with a budget of MAX_ITER subtractions.
  task automatic ref_gcd(input int a, input int b,
                         output int n, output bit abort, output int g);
    n = 0;
    abort = 0;
    forever begin
      if (a == b) begin
        g = a;
        break;
      end
      if (n == int'(MAX_ITER)) begin
        abort = 1;
        g = 0;
        break;
      end
      if (a > b) a = a - b;
      else       b = b - a;
      n++;
    end
  endtask

  // Stimulus/observation helper: issues start in the current cycle (T0),
  // optionally stalls in_valid low for `stall` cycles while re-pulsing start,
  // then supplies A and B. It reports the cycle of done relative to T0.
  task automatic run_gcd(input logic [15:0] a, input logic [15:0] b,
                         input int stall,
                         output int lat, output bit errv,
                         output logic [15:0] cnt,
                         output int both_loads, output int late_loads,
                         output int stall_bad, output bit post_ok);
    int  t     = 0;
    int  xfers = 0;
    bit  seen  = 0;
    lat        = -1;
    errv       = 0;
    cnt        = 'x;
    both_loads = 0;
    late_loads = 0;
    stall_bad  = 0;
    post_ok    = 0;
    data_in  = a;
    in_valid = (stall == 0);
    start    = 1'b1;
    while (!seen && t < 300) begin
      @(negedge clk);
      t++;
      start    = (t <= stall);
      in_valid = (t > stall);
      if (xfers == 1) data_in = b;
      #1;
      if (t <= stall && !(in_ready && !lda && !ldb && busy)) stall_bad++;
      if (lda && ldb) both_loads++;
      if (xfers >= 2 && (lda || ldb)) late_loads++;
      if (in_ready && in_valid) xfers++;
      if (done) begin
        seen = 1;
        lat  = t;
        errv = err;
        cnt  = iter_cnt;
      end
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    post_ok = seen && !done && !err && !busy && !lda && !ldb && !in_ready
              && (iter_cnt === cnt);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; data_in = 16'd3;
    @(negedge clk); #1;
    vectors++;
    if ({lda, ldb, sel_1, sel_2, sel_in, in_ready, busy, done, err} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 000000000",
               {lda, ldb, sel_1, sel_2, sel_in, in_ready, busy, done, err});
    end
    vectors++;
    if (iter_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_iter_cnt: got %0d expected 0", iter_cnt);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_hold: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_equal;
    int lat, bl, ll, sb; bit e, p; logic [15:0] c;
    run_gcd(16'd7, 16'd7, 0, lat, e, c, bl, ll, sb, p);
    vectors++;
    if (lat !== 4 || e !== 1'b0 || c !== 16'd0) begin
      miscompares++;
      $display("FAIL equal_7_7: lat=%0d err=%b cnt=%0d expected 4 0 0", lat, e, c);
    end
    vectors++;
    if (ll !== 0 || bl !== 0) begin
      miscompares++;
      $display("FAIL equal_loads: late=%0d both=%0d expected 0 0", ll, bl);
    end
    vectors++;
    if (p !== 1'b1 || a_reg !== 16'd7) begin
      miscompares++;
      $display("FAIL equal_post: post_ok=%b a=%0d expected 1 7", p, a_reg);
    end
  endtask

  task automatic test_12_18;
    int lat, bl, ll, sb; bit e, p; logic [15:0] c;
    run_gcd(16'd12, 16'd18, 0, lat, e, c, bl, ll, sb, p);
    vectors++;
    if (lat !== 8 || e !== 1'b0 || c !== 16'd2) begin
      miscompares++;
      $display("FAIL gcd_12_18: lat=%0d err=%b cnt=%0d expected 8 0 2", lat, e, c);
    end
    vectors++;
    if (a_reg !== 16'd6 || b_reg !== 16'd6 || bl !== 0 || p !== 1'b1) begin
      miscompares++;
      $display("FAIL gcd_12_18_regs: a=%0d b=%0d both=%0d post=%b expected 6 6 0 1",
               a_reg, b_reg, bl, p);
    end
  endtask

  task automatic test_abort_zero;
    int lat, bl, ll, sb; bit e, p; logic [15:0] c;
    run_gcd(16'd5, 16'd0, 0, lat, e, c, bl, ll, sb, p);
    vectors++;
    if (lat !== 4 + 2 * int'(MAX_ITER) || e !== 1'b1 || c !== 16'(MAX_ITER)) begin
      miscompares++;
      $display("FAIL abort_5_0: lat=%0d err=%b cnt=%0d expected %0d 1 %0d",
               lat, e, c, 4 + 2 * int'(MAX_ITER), MAX_ITER);
    end
    vectors++;
    if (p !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pulse: post_ok=%b expected 1 (single-cycle done/err)", p);
    end
  endtask

  task automatic test_stall;
    int lat, bl, ll, sb; bit e, p; logic [15:0] c;
    run_gcd(16'd12, 16'd18, 3, lat, e, c, bl, ll, sb, p);
    vectors++;
    if (sb !== 0) begin
      miscompares++;
      $display("FAIL stall_load_a: bad cycles=%0d expected 0", sb);
    end
    vectors++;
    if (lat !== 11 || e !== 1'b0 || c !== 16'd2) begin
      miscompares++;
      $display("FAIL stall_result: lat=%0d err=%b cnt=%0d expected 11 0 2", lat, e, c);
    end
  endtask

  task automatic test_reset_mid_sub;
    int lat, bl, ll, sb; bit e, p; logic [15:0] c;
    data_in = 16'd5; in_valid = 1'b1; start = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 2) data_in = 16'd0;
      if (t == 6) begin
        rst   = 1'b1;
        start = 1'b1;
      end
      #1;
    end
    vectors++;
    if (!(lda && sel_1 && !sel_2 && sel_in) || iter_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL midsub_in_sub_a: lda=%b sel_1=%b sel_2=%b cnt=%0d expected 1 1 0 1",
               lda, sel_1, sel_2, iter_cnt);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || iter_cnt !== 16'd0 || {lda, ldb, in_ready, done, err} !== 5'b0) begin
      miscompares++;
      $display("FAIL midsub_reset: busy=%b cnt=%0d ctl=%b expected 0 0 00000",
               busy, iter_cnt, {lda, ldb, in_ready, done, err});
    end
    run_gcd(16'd12, 16'd18, 0, lat, e, c, bl, ll, sb, p);
    vectors++;
    if (lat !== 8 || e !== 1'b0 || c !== 16'd2 || a_reg !== 16'd6) begin
      miscompares++;
      $display("FAIL midsub_rerun: lat=%0d err=%b cnt=%0d a=%0d expected 8 0 2 6",
               lat, e, c, a_reg);
    end
  endtask

  task automatic test_flag_conflict;
    int lat, bl, ll, sb; bit e, p; logic [15:0] c;
    force_lt = 1'b1;
    run_gcd(16'd9, 16'd4, 0, lat, e, c, bl, ll, sb, p);
    force_lt = 1'b0;
    vectors++;
    if (lat !== 4 || e !== 1'b1 || c !== 16'd0) begin
      miscompares++;
      $display("FAIL conflict_err: lat=%0d err=%b cnt=%0d expected 4 1 0", lat, e, c);
    end
    vectors++;
    if (p !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_pulse: post_ok=%b expected 1", p);
    end
  endtask

  task automatic test_random;
    int lat, bl, ll, sb, n, g; bit e, p, ab; logic [15:0] c;
    int ra, rb;
    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      if (ra == 0 && rb == 0) rb = 1;
      ref_gcd(ra, rb, n, ab, g);
      run_gcd(16'(ra), 16'(rb), 0, lat, e, c, bl, ll, sb, p);
      vectors++;
      if (lat !== 4 + 2 * n || e !== ab || c !== 16'(n) || bl !== 0 || p !== 1'b1) begin
        miscompares++;
        $display("FAIL random_%0d_%0d: lat=%0d err=%b cnt=%0d both=%0d post=%b expected %0d %b %0d 0 1",
                 ra, rb, lat, e, c, bl, p, 4 + 2 * n, ab, n);
      end
      if (!ab) begin
        vectors++;
        if (a_reg !== 16'(g)) begin
          miscompares++;
          $display("FAIL random_gcd_%0d_%0d: got %0d expected %0d", ra, rb, a_reg, g);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_equal;
    test_12_18;
    test_abort_zero;
    test_stall;
    test_reset_mid_sub;
    test_flag_conflict;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
